// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU data-SRAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic       ID_IFU         = 1'b0;
    localparam logic       ID_LSU         = 1'b1;
    localparam logic [1:0] DMEM_RESP_OKAY = 2'b00;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; bit 0 = IFU, bit 1 = LSU.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On conflict the requester that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read data SRAM port between the IFU and LSU.
// Optional grant/conflict performance counters with MEM_ARBITER_PERF_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PERF_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_resp_valid_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    output logic                ifu_resp_err_o,
    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic                lsu_wen_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    output logic                lsu_resp_valid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                lsu_resp_err_o,
    output logic                dmem_ren_o,
    output logic                dmem_wen_o,
    output logic [ADDR_W-1:0]   dmem_addr_o,
    output logic [DATA_W-1:0]   dmem_wdata_o,
    output logic [DATA_W/8-1:0] dmem_we_mask_o,
    input  logic [DATA_W-1:0]   dmem_rdata_i,
`ifdef MEM_ARBITER_PERF_EN
    output logic [PERF_W-1:0]   ifu_grant_cnt_o,
    output logic [PERF_W-1:0]   lsu_grant_cnt_o,
    output logic [PERF_W-1:0]   conflict_cnt_o,
`endif
    input  logic [1:0]          dmem_resp_i
);

    localparam int unsigned MASK_W = DATA_W / 8;

    state_e              state_q;
    state_e              state_d;
    logic                accept;
    logic [1:0]          grant;
    logic                last_grant_q;
    logic                id_q;
    logic                wen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic                issue_ren_q;
    logic                issue_wen_q;
    logic                resp_err;

    rr_arb2 u_rr_arb2 (
        .req        ({lsu_req_valid_i, ifu_req_valid_i}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed IDLE -> ISSUE -> RESP walk; a request is taken only in IDLE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch; the SRAM strobes are set on acceptance so they are high only in ISSUE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_q <= ID_LSU;
            id_q         <= ID_IFU;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            issue_ren_q  <= 1'b0;
            issue_wen_q  <= 1'b0;
        end else begin
            issue_ren_q <= 1'b0;
            issue_wen_q <= 1'b0;
            if (accept) begin
                if (grant[1]) begin
                    id_q         <= ID_LSU;
                    last_grant_q <= ID_LSU;
                    wen_q        <= lsu_wen_i;
                    addr_q       <= lsu_addr_i;
                    wdata_q      <= lsu_wdata_i;
                    wmask_q      <= lsu_wmask_i;
                    issue_ren_q  <= ~lsu_wen_i;
                    issue_wen_q  <= lsu_wen_i;
                end else begin
                    id_q         <= ID_IFU;
                    last_grant_q <= ID_IFU;
                    wen_q        <= 1'b0;
                    addr_q       <= ifu_addr_i;
                    wdata_q      <= '0;
                    wmask_q      <= '0;
                    issue_ren_q  <= 1'b1;
                end
            end
        end
    end

    assign ifu_req_ready_o = (state_q == IDLE) && grant[0];
    assign lsu_req_ready_o = (state_q == IDLE) && grant[1];

    assign dmem_ren_o     = issue_ren_q;
    assign dmem_wen_o     = issue_wen_q;
    assign dmem_addr_o    = addr_q;
    assign dmem_wdata_o   = wdata_q;
    assign dmem_we_mask_o = wmask_q;

    // SRAM data arrives registered in RESP, so it is steered straight through.
    assign resp_err         = (dmem_resp_i != DMEM_RESP_OKAY);
    assign ifu_resp_valid_o = (state_q == RESP) && (id_q == ID_IFU);
    assign lsu_resp_valid_o = (state_q == RESP) && (id_q == ID_LSU);
    assign ifu_rdata_o      = ifu_resp_valid_o ? dmem_rdata_i : '0;
    assign lsu_rdata_o      = (lsu_resp_valid_o && !wen_q) ? dmem_rdata_i : '0;
    assign ifu_resp_err_o   = ifu_resp_valid_o && resp_err;
    assign lsu_resp_err_o   = lsu_resp_valid_o && resp_err;

`ifdef MEM_ARBITER_PERF_EN
    logic conflict;

    assign conflict = (state_q == IDLE) && ifu_req_valid_i && lsu_req_valid_i;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ifu_grant_cnt_o <= '0;
            lsu_grant_cnt_o <= '0;
            conflict_cnt_o  <= '0;
        end else begin
            if (ifu_req_ready_o && (ifu_grant_cnt_o != '1)) begin
                ifu_grant_cnt_o <= ifu_grant_cnt_o + PERF_W'(1);
            end
            if (lsu_req_ready_o && (lsu_grant_cnt_o != '1)) begin
                lsu_grant_cnt_o <= lsu_grant_cnt_o + PERF_W'(1);
            end
            if (conflict && (conflict_cnt_o != '1)) begin
                conflict_cnt_o <= conflict_cnt_o + PERF_W'(1);
            end
        end
    end
`else
    logic unused_perf_w;

    assign unused_perf_w = ^PERF_W;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs sampled at negedge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_we_mask;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] ifu_grant_cnt;
    logic [31:0] lsu_grant_cnt;
    logic [31:0] conflict_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    mem_arbiter dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .ifu_req_valid_i  (ifu_req_valid),
        .ifu_req_ready_o  (ifu_req_ready),
        .ifu_addr_i       (ifu_addr),
        .ifu_resp_valid_o (ifu_resp_valid),
        .ifu_rdata_o      (ifu_rdata),
        .ifu_resp_err_o   (ifu_resp_err),
        .lsu_req_valid_i  (lsu_req_valid),
        .lsu_req_ready_o  (lsu_req_ready),
        .lsu_wen_i        (lsu_wen),
        .lsu_addr_i       (lsu_addr),
        .lsu_wdata_i      (lsu_wdata),
        .lsu_wmask_i      (lsu_wmask),
        .lsu_resp_valid_o (lsu_resp_valid),
        .lsu_rdata_o      (lsu_rdata),
        .lsu_resp_err_o   (lsu_resp_err),
        .dmem_ren_o       (dmem_ren),
        .dmem_wen_o       (dmem_wen),
        .dmem_addr_o      (dmem_addr),
        .dmem_wdata_o     (dmem_wdata),
        .dmem_we_mask_o   (dmem_we_mask),
        .dmem_rdata_i     (dmem_rdata),
`ifdef MEM_ARBITER_PERF_EN
        .ifu_grant_cnt_o  (ifu_grant_cnt),
        .lsu_grant_cnt_o  (lsu_grant_cnt),
        .conflict_cnt_o   (conflict_cnt),
`endif
        .dmem_resp_i      (dmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every output is zero: used after reset and while idle with no response.
    task automatic chk_quiet(input string tag);
        chk({tag, " resp"}, {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        chk({tag, " err"}, {62'd0, ifu_resp_err, lsu_resp_err}, 64'd0);
        chk({tag, " rdata"}, {ifu_rdata, lsu_rdata}, 64'd0);
        chk({tag, " en"}, {62'd0, dmem_ren, dmem_wen}, 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        lsu_addr      = '0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        dmem_rdata    = '0;
        dmem_resp     = 2'b00;

        // Reset state
        #2;
        chk_quiet("reset");
        chk("reset addr", {32'd0, dmem_addr}, 64'd0);
        chk("reset ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // IFU-only read; a stray lsu_wen must not turn it into a write
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        lsu_wen       = 1'b1;
        #1;
        chk("ifu rd ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
        chk("ifu rd no en c0", {62'd0, dmem_ren, dmem_wen}, 64'd0);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        dmem_rdata    = 32'hCAFE_F00D;
        #1;
        chk("ifu rd issue en", {62'd0, dmem_ren, dmem_wen}, 64'd2);
        chk("ifu rd issue addr", {32'd0, dmem_addr}, 64'h8000_0000);
        chk("ifu rd issue mask", {60'd0, dmem_we_mask}, 64'd0);
        @(negedge clk);
        #1;
        chk("ifu rd resp valid", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd2);
        chk("ifu rd rdata", {32'd0, ifu_rdata}, 64'hCAFE_F00D);
        chk("ifu rd err", {62'd0, ifu_resp_err, lsu_resp_err}, 64'd0);
        chk("ifu rd resp en", {62'd0, dmem_ren, dmem_wen}, 64'd0);
        @(negedge clk);
        #1;
        chk_quiet("ifu rd after");
        chk("ifu rd addr hold", {32'd0, dmem_addr}, 64'h8000_0000);

        // LSU write
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 32'h8000_0100;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'b0011;
        #1;
        chk("lsu wr ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        dmem_rdata    = 32'h1111_1111;
        #1;
        chk("lsu wr issue en", {62'd0, dmem_ren, dmem_wen}, 64'd1);
        chk("lsu wr issue addr", {32'd0, dmem_addr}, 64'h8000_0100);
        chk("lsu wr issue wdata", {32'd0, dmem_wdata}, 64'hDEAD_BEEF);
        chk("lsu wr issue mask", {60'd0, dmem_we_mask}, 64'd3);
        @(negedge clk);
        #1;
        chk("lsu wr resp valid", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd1);
        chk("lsu wr rdata zero", {ifu_rdata, lsu_rdata}, 64'd0);
        chk("lsu wr resp en", {62'd0, dmem_ren, dmem_wen}, 64'd0);
        @(negedge clk);
        #1;
        chk_quiet("lsu wr after");

        // Both valid continuously: IFU, LSU, IFU, LSU, one acceptance every 3 cycles
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0080;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h0000_0040;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk($sformatf("conf%0d ready", i), {62'd0, ifu_req_ready, lsu_req_ready},
                (i % 2 == 0) ? 64'd2 : 64'd1);
            @(negedge clk);
            dmem_rdata = 32'hA000_0000 + 32'(i);
            #1;
            chk($sformatf("conf%0d issue", i), {31'd0, dmem_ren, dmem_addr},
                (i % 2 == 0) ? 64'h1_0000_0080 : 64'h1_0000_0040);
            chk($sformatf("conf%0d busy ready", i), {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
            @(negedge clk);
            #1;
            chk($sformatf("conf%0d resp", i), {62'd0, ifu_resp_valid, lsu_resp_valid},
                (i % 2 == 0) ? 64'd2 : 64'd1);
            chk($sformatf("conf%0d rdata", i), {ifu_rdata, lsu_rdata},
                (i % 2 == 0) ? {32'hA000_0000 + 32'(i), 32'd0} : {32'd0, 32'hA000_0000 + 32'(i)});
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;

        // LSU read with SRAM error response
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_0200;
        #1;
        chk("err ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        dmem_rdata    = 32'h5555_AAAA;
        dmem_resp     = 2'b01;
        #1;
        chk("err issue en", {62'd0, dmem_ren, dmem_wen}, 64'd2);
        @(negedge clk);
        #1;
        chk("err resp", {60'd0, ifu_resp_valid, ifu_resp_err, lsu_resp_valid, lsu_resp_err}, 64'd3);
        chk("err rdata", {32'd0, lsu_rdata}, 64'h5555_AAAA);
        @(negedge clk);
        dmem_resp = 2'b00;
        #1;
        chk_quiet("err after");

        // Reset during ISSUE of an LSU write
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 32'h0000_0300;
        lsu_wdata     = 32'h0BAD_F00D;
        lsu_wmask     = 4'b0000;
        #1;
        chk("rst ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        #1;
        chk("rst mask0 issue", {62'd0, dmem_ren, dmem_wen}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk_quiet("rst mid");
        chk("rst mid addr", {32'd0, dmem_addr}, 64'd0);
        chk("rst mid wdata", {32'd0, dmem_wdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_quiet("rst rel c0");
        @(negedge clk);
        #1;
        chk_quiet("rst rel c1");

        // First conflict after reset goes to IFU, then LSU; normal latency
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0400;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h0000_0500;
        #1;
        chk("post rst grant", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        dmem_rdata    = 32'h1234_5678;
        #1;
        chk("post rst issue", {31'd0, dmem_ren, dmem_addr}, 64'h1_0000_0400);
        @(negedge clk);
        #1;
        chk("post rst resp", {30'd0, ifu_resp_valid, lsu_resp_valid, ifu_rdata}, 64'h2_1234_5678);
        @(negedge clk);
        #1;
        chk("post rst lsu ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        dmem_rdata    = 32'h8765_4321;
        #1;
        chk("post rst lsu issue", {31'd0, dmem_ren, dmem_addr}, 64'h1_0000_0500);
        @(negedge clk);
        #1;
        chk("post rst lsu resp", {30'd0, ifu_resp_valid, lsu_resp_valid, lsu_rdata}, 64'h1_8765_4321);

`ifdef MEM_ARBITER_PERF_EN
        // Since the last reset: one IFU grant, one LSU grant, one conflict cycle
        chk("perf ifu", {32'd0, ifu_grant_cnt}, 64'd1);
        chk("perf lsu", {32'd0, lsu_grant_cnt}, 64'd1);
        chk("perf conflict", {32'd0, conflict_cnt}, 64'd1);
`endif

        @(negedge clk);
        #1;
        chk_quiet("final idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data SRAM port between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Accepts one request at a time through valid/ready handshakes and arbitrates round-robin when both requesters are valid.
- Drives the SRAM's registered-read port and routes the returned data or error back to the requester that issued the request.
- Sits between the IFU/LSU and the data SRAM in the NPC core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the write mask is DATA_W/8 bits.
- PERF_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- ifu_req_valid_i  in  1  IFU read request.
- ifu_req_ready_o  out  1  IFU request accepted this cycle.
- ifu_addr_i  in  ADDR_W  IFU read address.
- ifu_resp_valid_o  out  1  one-cycle pulse: IFU data valid.
- ifu_rdata_o  out  DATA_W  IFU read data.
- ifu_resp_err_o  out  1  IFU access error; qualified by ifu_resp_valid_o.
- lsu_req_valid_i  in  1  LSU request.
- lsu_req_ready_o  out  1  LSU request accepted this cycle.
- lsu_wen_i  in  1  1 = write, 0 = read.
- lsu_addr_i  in  ADDR_W  LSU address.
- lsu_wdata_i  in  DATA_W  LSU write data.
- lsu_wmask_i  in  DATA_W/8  LSU byte-write mask.
- lsu_resp_valid_o  out  1  one-cycle pulse: LSU read data or write completion.
- lsu_rdata_o  out  DATA_W  LSU read data; 0 for writes.
- lsu_resp_err_o  out  1  LSU access error; qualified by lsu_resp_valid_o.
- dmem_ren_o  out  1  SRAM read enable.
- dmem_wen_o  out  1  SRAM write enable.
- dmem_addr_o  out  ADDR_W  SRAM address.
- dmem_wdata_o  out  DATA_W  SRAM write data.
- dmem_we_mask_o  out  DATA_W/8  SRAM byte-write mask.
- dmem_rdata_i  in  DATA_W  SRAM read data, registered inside the SRAM.
- dmem_resp_i  in  2  SRAM response code; 2'b00 = OK.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE; all outputs are 0.
  - Latched request fields are cleared; last_grant = LSU, so the IFU wins the first conflict.
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready_o is combinational: ready = valid AND granted; never high outside IDLE.
  - Only one ready is asserted per cycle.
  - Grant rules:
    - only one requester valid -> that requester is granted;
    - both valid -> the requester that is not last_grant is granted.
  - On acceptance: latch id, addr, wen, wdata, wmask; update last_grant; go to ISSUE.
  - No valid request -> stay in IDLE.
- ISSUE (one cycle):
  - Drive dmem_addr_o, dmem_wdata_o and dmem_we_mask_o from the latched request.
  - Read: dmem_ren_o = 1. Write: dmem_wen_o = 1.
  - Go to RESP.
- RESP (one cycle):
  - Assert resp_valid_o for the latched id only.
  - rdata_o = dmem_rdata_i for reads, 0 for writes.
  - resp_err_o = (dmem_resp_i != 2'b00).
  - Go to IDLE.
- Outside ISSUE: dmem enables are 0; addr/wdata/mask hold their last values.
- Outside RESP: resp_valid_o, resp_err_o and rdata_o are 0.
- Latency and throughput:
  - Acceptance in cycle T -> ISSUE in T+1 -> resp_valid_o in T+2.
  - Maximum throughput is one request per 3 cycles.
- Requesters have no response backpressure; they must take the response pulse when it is presented.
- Request inputs are ignored while not in IDLE; requesters hold valid until they see ready.
- An IFU request with lsu_wen_i = 1 is irrelevant: IFU requests are always reads.
- The address is passed through unmodified; no alignment check is made.
- A write with mask 0 still performs the ISSUE/RESP sequence.
- Reset asserted mid-operation (ISSUE or RESP) aborts the in-flight request: no response is produced and no SRAM enable is left asserted.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- Defined:
  - Adds outputs ifu_grant_cnt_o, lsu_grant_cnt_o and conflict_cnt_o, each PERF_W wide.
  - ifu_grant_cnt_o / lsu_grant_cnt_o count accepted requests per requester.
  - conflict_cnt_o counts IDLE cycles in which both requesters are valid.
  - All counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters do not exist; the behaviour is otherwise identical.

Decomposition:
- Package mem_arbiter_pkg:
  - state enum {IDLE, ISSUE, RESP};
  - requester id constants ID_IFU = 1'b0, ID_LSU = 1'b1;
  - DMEM_RESP_OKAY = 2'b00.
- Sub-module rr_arb2: combinational 2-way round-robin picker with inputs (req[1:0], last_grant) and one-hot grant[1:0] output. The last_grant register stays in mem_arbiter.

Test Plan:
- IFU-only read: ifu addr 0x8000_0000 valid at cycle 0 -> ifu_req_ready_o high in cycle 0, dmem_ren_o high in cycle 1, ifu_resp_valid_o high in cycle 2 with rdata = SRAM word, lsu_resp_valid_o stays 0.
- LSU write: addr 0x8000_0100, wdata 0xDEAD_BEEF, mask 4'b0011 -> dmem_wen_o high for exactly one cycle with those values, lsu_resp_valid_o in cycle 2, lsu_rdata_o = 0, ifu outputs quiet.
- Conflict after reset: both valid continuously -> grant order IFU, LSU, IFU, LSU with acceptances 3 cycles apart; each response goes to the correct requester.
- Error path: dmem_resp_i = 2'b01 during an LSU read RESP cycle -> lsu_resp_err_o = 1 together with lsu_resp_valid_o; ifu_resp_err_o = 0.
- Reset mid-operation: assert rst_n_i = 0 during ISSUE -> all outputs 0 immediately; after release, no stale response; next request gives normal 2-cycle latency; first conflict goes to the IFU.
- With MEM_ARBITER_PERF_EN: 5 conflicting IDLE cycles plus 3 IFU and 2 LSU grants -> counters read 5/3/2; a forced near-max value saturates at all-ones.
